// File: rtl/adc_cmd_arbiter_if.sv
// Command-channel bundle between two requesters, the arbiter and the ADC SPI engine.
// Purely structural: no logic, no latency.
// Backpressure is carried by the tready signals in each direction.
interface adc_cmd_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] s0_axis_tdata;
  logic                  s0_axis_tvalid;
  logic                  s0_axis_tready;
  logic [DATA_WIDTH-1:0] s1_axis_tdata;
  logic                  s1_axis_tvalid;
  logic                  s1_axis_tready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tid;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;

  // Arbiter view: receives both requester streams and drives the SPI-engine stream.
  modport slave (
    input  s0_axis_tdata, s0_axis_tvalid,
    output s0_axis_tready,
    input  s1_axis_tdata, s1_axis_tvalid,
    output s1_axis_tready,
    output m_axis_tdata, m_axis_tid, m_axis_tvalid,
    input  m_axis_tready
  );

  // Environment view: drives requesters and acts as the SPI engine.
  modport master (
    output s0_axis_tdata, s0_axis_tvalid,
    input  s0_axis_tready,
    output s1_axis_tdata, s1_axis_tvalid,
    input  s1_axis_tready,
    input  m_axis_tdata, m_axis_tid, m_axis_tvalid,
    output m_axis_tready
  );
endinterface

// File: rtl/adc_cmd_arbiter.sv
// Two-port command arbiter (fixed or round-robin) into the ADC SPI engine, with post-frame idle gap.
// Latency: accepted command appears on m_axis one cycle after accept; period >= 2+GAP_CYCLES.
// Backpressure: m_axis_tready low holds the word in SEND; both upstream treadys stay low outside IDLE.
module adc_cmd_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int GAP_CYCLES = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 aclk,
  input  logic                 areset,
  adc_cmd_arbiter_if.slave     bus,
  input  logic                 fixed_priority,
  input  logic                 clear_cnt,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] cnt0,
  output logic [CNT_WIDTH-1:0] cnt1
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [GW-1:0]        GAP_LOAD = GW'(GAP_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [1:0]            r_state;
  logic [GW-1:0]         r_gap;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tid;
  logic                  r_tvalid;
  logic                  r_last_grant;
  logic [CNT_WIDTH-1:0]  r_cnt0;
  logic [CNT_WIDTH-1:0]  r_cnt1;

  logic w_idle;
  logic w_gnt_vld;
  logic w_gnt_port;
  logic w_acc0;
  logic w_acc1;

  assign w_idle = (r_state == ST_IDLE);

  // Grant decision: only in IDLE and never while reset is held; contention resolved by priority mode.
  always_comb begin
    w_gnt_vld  = w_idle && !areset && (bus.s0_axis_tvalid || bus.s1_axis_tvalid);
    w_gnt_port = 1'b0;
    if (bus.s0_axis_tvalid && bus.s1_axis_tvalid) begin
      w_gnt_port = fixed_priority ? 1'b0 : ~r_last_grant;
    end else begin
      w_gnt_port = bus.s1_axis_tvalid;
    end
  end

  assign w_acc0 = w_gnt_vld && !w_gnt_port;
  assign w_acc1 = w_gnt_vld &&  w_gnt_port;

  assign bus.s0_axis_tready = w_acc0;
  assign bus.s1_axis_tready = w_acc1;
  assign bus.m_axis_tdata   = r_tdata;
  assign bus.m_axis_tid     = r_tid;
  assign bus.m_axis_tvalid  = r_tvalid;
  assign busy               = !w_idle;
  assign cnt0               = r_cnt0;
  assign cnt1               = r_cnt1;

  // Control FSM: capture granted word, hold it until the SPI engine takes it, then enforce the idle gap.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_state      <= ST_IDLE;
      r_gap        <= '0;
      r_tdata      <= '0;
      r_tid        <= 1'b0;
      r_tvalid     <= 1'b0;
      r_last_grant <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_tdata      <= w_gnt_port ? bus.s1_axis_tdata : bus.s0_axis_tdata;
            r_tid        <= w_gnt_port;
            r_last_grant <= w_gnt_port;
            r_tvalid     <= 1'b1;
            r_state      <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bus.m_axis_tready) begin
            r_tvalid <= 1'b0;
            if (GAP_CYCLES == 0) begin
              r_state <= ST_IDLE;
            end else begin
              r_gap   <= GAP_LOAD;
              r_state <= ST_GAP;
            end
          end
        end
        ST_GAP: begin
          if (r_gap <= GW'(1)) begin
            r_state <= ST_IDLE;
          end else begin
            r_gap <= r_gap - GW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Saturating per-port accept counters; a clear wins over a same-cycle increment.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (clear_cnt) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_acc0 && (r_cnt0 != CNT_MAX)) r_cnt0 <= r_cnt0 + CNT_WIDTH'(1);
      if (w_acc1 && (r_cnt1 != CNT_MAX)) r_cnt1 <= r_cnt1 + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_adc_cmd_arbiter.sv
// Self-checking bench for adc_cmd_arbiter: directed scenarios plus a randomized run.
// Expected behaviour comes from a timestamp-based transaction model kept in the bench.
// Outputs are sampled 1 time unit after the falling edge, inputs change on the falling edge.
module tb_adc_cmd_arbiter;
  localparam int DW   = 32;
  localparam int GAP  = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          fixed_priority = 1'b0;
  logic          clear_cnt = 1'b0;
  logic          busy;
  logic [CW-1:0] cnt0;
  logic [CW-1:0] cnt1;

  adc_cmd_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  adc_cmd_arbiter #(.DATA_WIDTH(DW), .GAP_CYCLES(GAP), .CNT_WIDTH(CW)) dut (
    .aclk           (aclk),
    .areset         (areset),
    .bus            (bus.slave),
    .fixed_priority (fixed_priority),
    .clear_cnt      (clear_cnt),
    .busy           (busy),
    .cnt0           (cnt0),
    .cnt1           (cnt1)
  );

  always #5 aclk = ~aclk;

  int tests = 0;
  int fails = 0;

  // Model: one word may be in flight; after it is delivered the channel is free again at a timestamp.
  int          cyc = 0;
  bit          md_infl;
  logic [31:0] md_data;
  bit          md_tid;
  bit          md_last;
  int          md_idle_at;
  int          md_c0;
  int          md_c1;
  bit          out_tid[$];
  logic [31:0] out_dat[$];

  logic o_busy, o_s0r, o_s1r;
  int   o_cnt0, o_cnt1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    areset = 1'b1;
    bus.s0_axis_tvalid = 1'b1;
    bus.s1_axis_tvalid = 1'b1;
    bus.m_axis_tready  = 1'b0;
    clear_cnt = 1'b0;
    #1;
    chk("rst_tvalid", bus.m_axis_tvalid, 0);
    chk("rst_tdata",  bus.m_axis_tdata, 0);
    chk("rst_tid",    bus.m_axis_tid, 0);
    chk("rst_busy",   busy, 0);
    chk("rst_s0rdy",  bus.s0_axis_tready, 0);
    chk("rst_s1rdy",  bus.s1_axis_tready, 0);
    chk("rst_cnt0",   cnt0, 0);
    chk("rst_cnt1",   cnt1, 0);
    md_infl = 0; md_last = 1; md_c0 = 0; md_c1 = 0; md_idle_at = cyc;
    @(negedge aclk);
    bus.s0_axis_tvalid = 1'b0;
    bus.s1_axis_tvalid = 1'b0;
    areset = 1'b0;
  endtask

  // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic step(input bit v0, input logic [31:0] d0, input bit v1, input logic [31:0] d1,
                      input bit mrdy, input bit fp, input bit clr);
    bit idle, gvld, gport;
    @(negedge aclk);
    bus.s0_axis_tvalid = v0; bus.s0_axis_tdata = d0;
    bus.s1_axis_tvalid = v1; bus.s1_axis_tdata = d1;
    bus.m_axis_tready = mrdy; fixed_priority = fp; clear_cnt = clr;
    #1;
    idle  = !md_infl && (cyc >= md_idle_at);
    gvld  = idle && (v0 || v1);
    gport = (v0 && v1) ? (fp ? 1'b0 : !md_last) : v1;
    chk("busy",   busy, !idle);
    chk("tvalid", bus.m_axis_tvalid, md_infl);
    if (md_infl) begin
      chk("tdata", bus.m_axis_tdata, md_data);
      chk("tid",   bus.m_axis_tid, md_tid);
    end
    chk("s0_rdy", bus.s0_axis_tready, gvld && !gport);
    chk("s1_rdy", bus.s1_axis_tready, gvld && gport);
    chk("cnt0",   cnt0, md_c0);
    chk("cnt1",   cnt1, md_c1);
    o_busy = busy; o_s0r = bus.s0_axis_tready; o_s1r = bus.s1_axis_tready;
    o_cnt0 = int'(cnt0); o_cnt1 = int'(cnt1);
    if (md_infl && mrdy) begin
      md_infl = 0;
      md_idle_at = cyc + 1 + GAP;
      out_tid.push_back(md_tid);
      out_dat.push_back(md_data);
    end
    if (gvld) begin
      md_infl = 1; md_tid = gport; md_last = gport;
      md_data = gport ? d1 : d0;
      if (gport) md_c1 = (md_c1 < CMAX) ? md_c1 + 1 : CMAX;
      else       md_c0 = (md_c0 < CMAX) ? md_c0 + 1 : CMAX;
    end
    if (clr) begin md_c0 = 0; md_c1 = 0; end
    cyc++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, first_rdy, any_rdy, sat_cnt, all0;
    bit acc;
    bus.s0_axis_tdata = '0; bus.s1_axis_tdata = '0;
    bus.s0_axis_tvalid = 0; bus.s1_axis_tvalid = 0; bus.m_axis_tready = 0;

    // Single port-0 command: latency, busy window, next-ready timing.
    do_reset();
    out_tid.delete(); out_dat.delete();
    step(1, 32'hA5A5_0001, 0, 0, 1, 0, 0);
    nb = 0; first_rdy = -1;
    for (int k = 1; k <= 7; k++) begin
      step(1, 32'hA5A5_0002, 0, 0, 1, 0, 0);
      if (k == 1) chk("t1_cnt0", o_cnt0, 1);
      if (k <= 6 && o_busy) nb++;
      if (o_s0r && first_rdy < 0) first_rdy = k;
    end
    chk("t1_busy_cycles", nb, 5);
    chk("t1_next_rdy", first_rdy, 6);
    chk("t1_first_dat", out_dat.size() > 0 ? out_dat[0] : 32'hx, 32'hA5A5_0001);
    chk("t1_first_tid", out_tid.size() > 0 ? out_tid[0] : 1'bx, 0);

    // Round-robin with both ports continuously valid.
    do_reset();
    out_tid.delete(); out_dat.delete();
    for (int k = 0; k < 200 && out_tid.size() < 6; k++)
      step(1, $urandom, 1, $urandom, 1, 0, 0);
    chk("t2_outs", out_tid.size(), 6);
    if (out_tid.size() == 6)
      for (int i = 0; i < 6; i++) chk("t2_rr_tid", out_tid[i], i % 2);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t2_cnt0", o_cnt0, 3);
    chk("t2_cnt1", o_cnt1, 3);

    // Fixed priority: port 1 starves.
    do_reset();
    out_tid.delete(); out_dat.delete();
    any_rdy = 0;
    for (int k = 0; k < 200 && out_tid.size() < 4; k++) begin
      step(1, $urandom, 1, $urandom, 1, 1, 0);
      if (o_s1r) any_rdy = 1;
    end
    chk("t3_outs", out_tid.size(), 4);
    all0 = 1;
    foreach (out_tid[i]) if (out_tid[i] != 0) all0 = 0;
    chk("t3_all_tid0", all0, 1);
    chk("t3_s1_never_rdy", any_rdy, 0);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("t3_cnt1", o_cnt1, 0);

    // Downstream backpressure for 10 cycles.
    do_reset();
    out_tid.delete(); out_dat.delete();
    step(1, 32'hC0DE_0004, 0, 0, 0, 0, 0);
    any_rdy = 0;
    for (int k = 0; k < 10; k++) begin
      step(1, $urandom, 1, $urandom, 0, $urandom_range(0, 1), 0);
      if (o_s0r || o_s1r) any_rdy = 1;
    end
    chk("t4_no_rdy", any_rdy, 0);
    chk("t4_held_outs", out_tid.size(), 0);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t4_outs", out_tid.size(), 1);
    chk("t4_dat", out_dat.size() > 0 ? out_dat[0] : 32'hx, 32'hC0DE_0004);

    // Counter saturation and clear coincident with an accept.
    do_reset();
    out_tid.delete(); out_dat.delete();
    for (int k = 0; k < 200 && out_tid.size() < 5; k++)
      step(0, 0, 1, $urandom, 1, 0, 0);
    sat_cnt = -1;
    for (int k = 0; k < 20; k++) begin
      acc = !md_infl && (cyc >= md_idle_at);
      step(0, 0, 1, $urandom, 1, 0, acc);
      if (k == 0) sat_cnt = o_cnt1;
      if (acc) break;
    end
    chk("t5_sat", sat_cnt, CMAX);
    step(0, 0, 0, 0, 1, 0, 0);
    chk("t5_clear", o_cnt1, 0);

    // Reset during SEND, then a normal port-1 transfer.
    do_reset();
    step(0, 0, 1, 32'h1111_0006, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    do_reset();
    out_tid.delete(); out_dat.delete();
    for (int k = 0; k < 20 && out_tid.size() < 1; k++)
      step(0, 0, 1, 32'h2222_0006, 1, 0, 0);
    chk("t6_outs", out_tid.size(), 1);
    chk("t6_tid", out_tid.size() > 0 ? out_tid[0] : 1'bx, 1);
    chk("t6_dat", out_dat.size() > 0 ? out_dat[0] : 32'hx, 32'h2222_0006);

    // Randomized traffic checked cycle by cycle against the model.
    do_reset();
    for (int k = 0; k < 600; k++)
      step($urandom_range(0, 1), $urandom, $urandom_range(0, 1), $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 31) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
